regfile4_onehot: RTL and testbench

A 4-entry register bank for the final-project register file. It sits directly downstream of the 2:4 write-address decoder and consumes that decoder's one-hot select lines as its write strobes. It provides two registered read ports with a single-cycle valid pulse, write-first bypass, a sticky select-error flag and a saturating write counter.

---
 rtl/regfile4_onehot.sv | 111 +++++++++++
 tb/tb_regfile4_onehot.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile4_onehot.sv
// Four-entry register bank. Its write strobes are the one-hot select lines from
// the 2:4 write-address decoder. It has two registered read ports with write-first
// bypass, a sticky multi-hot select error flag and a saturating write counter.
module regfile4_onehot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic [1:0]       ra_addr,
    input  logic [1:0]       rb_addr,
    input  logic             rd_req,
    input  logic             clr_err,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    output logic             rd_valid,
    output logic             sel_err,
    output logic [7:0]       wr_count
);

    localparam int unsigned NUM_REGS  = 4;
    localparam int unsigned CNT_W     = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] reg_q [NUM_REGS];
    logic [WIDTH-1:0] reg_d [NUM_REGS];
    logic [WIDTH-1:0] ra_data_q, ra_data_d;
    logic [WIDTH-1:0] rb_data_q, rb_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             sel_err_q, sel_err_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;

    logic             wr_any_c;
    logic             wr_legal_c;
    logic             wr_illegal_c;

    // Classify the select: idle, exactly one bit (legal), or multi-hot (illegal).
    always_comb begin
        wr_any_c     = |wsel;
        wr_legal_c   = wr_any_c && ((wsel & (wsel - 4'd1)) == 4'd0);
        wr_illegal_c = wr_any_c && !wr_legal_c;
    end

    // Next-state for the register array, read ports, error flag and counter.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_d[i] = reg_q[i];
        end
        ra_data_d  = ra_data_q;
        rb_data_d  = rb_data_q;
        rd_valid_d = 1'b0;
        sel_err_d  = sel_err_q;
        wr_count_d = wr_count_q;

        if (wr_legal_c) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wsel[i]) begin
                    reg_d[i] = wdata;
                end
            end
            if (wr_count_q != CNT_MAX) begin
                wr_count_d = wr_count_q + CNT_W'(1);
            end
        end

        // A set from an illegal select takes priority over a clear.
        if (wr_illegal_c) begin
            sel_err_d = 1'b1;
        end else if (clr_err) begin
            sel_err_d = 1'b0;
        end

        // Write-first: a legal write to the addressed entry forwards wdata.
        if (rd_req) begin
            rd_valid_d = 1'b1;
            ra_data_d  = (wr_legal_c && wsel[ra_addr]) ? wdata : reg_q[ra_addr];
            rb_data_d  = (wr_legal_c && wsel[rb_addr]) ? wdata : reg_q[rb_addr];
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= '0;
            end
            ra_data_q  <= '0;
            rb_data_q  <= '0;
            rd_valid_q <= 1'b0;
            sel_err_q  <= 1'b0;
            wr_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= reg_d[i];
            end
            ra_data_q  <= ra_data_d;
            rb_data_q  <= rb_data_d;
            rd_valid_q <= rd_valid_d;
            sel_err_q  <= sel_err_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign ra_data  = ra_data_q;
    assign rb_data  = rb_data_q;
    assign rd_valid = rd_valid_q;
    assign sel_err  = sel_err_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile4_onehot.sv
// Directed bench for regfile4_onehot: reset, writes, bypass, illegal select,
// counter saturation and asynchronous reset in the middle of an operation.
module tb_regfile4_onehot;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [3:0]       wsel;
    logic [WIDTH-1:0] wdata;
    logic [1:0]       ra_addr;
    logic [1:0]       rb_addr;
    logic             rd_req;
    logic             clr_err;
    logic [WIDTH-1:0] ra_data;
    logic [WIDTH-1:0] rb_data;
    logic             rd_valid;
    logic             sel_err;
    logic [7:0]       wr_count;

    int tests_run;
    int tests_failed;

    regfile4_onehot #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wsel     (wsel),
        .wdata    (wdata),
        .ra_addr  (ra_addr),
        .rb_addr  (rb_addr),
        .rd_req   (rd_req),
        .clr_err  (clr_err),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .rd_valid (rd_valid),
        .sel_err  (sel_err),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        wsel    = 4'b0000;
        wdata   = '0;
        ra_addr = 2'd0;
        rb_addr = 2'd0;
        rd_req  = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        idle_inputs();
        rst_n = 1'b0;

        // Reset state, reached without a clock edge.
        #2;
        chk("rst_async_valid", 32'(rd_valid), 32'h0);
        chk("rst_async_count", 32'(wr_count), 32'h0);
        tick();
        tick();

        // Release, then read reg0 and reg3.
        rst_n   = 1'b1;
        rd_req  = 1'b1;
        ra_addr = 2'd0;
        rb_addr = 2'd3;
        tick();
        chk("idle_rd_valid", 32'(rd_valid), 32'h1);
        chk("idle_ra", 32'(ra_data), 32'h00);
        chk("idle_rb", 32'(rb_data), 32'h00);
        chk("idle_sel_err", 32'(sel_err), 32'h0);
        chk("idle_count", 32'(wr_count), 32'h0);
        rd_req = 1'b0;
        tick();
        chk("idle_valid_drop", 32'(rd_valid), 32'h0);

        // Write all four registers.
        wsel = 4'b0001; wdata = 8'h11; tick();
        wsel = 4'b0010; wdata = 8'h22; tick();
        wsel = 4'b0100; wdata = 8'h33; tick();
        wsel = 4'b1000; wdata = 8'h44; tick();
        wsel = 4'b0000;
        rd_req = 1'b1; ra_addr = 2'd2; rb_addr = 2'd1;
        tick();
        chk("wr4_ra", 32'(ra_data), 32'h33);
        chk("wr4_rb", 32'(rb_data), 32'h22);
        chk("wr4_count", 32'(wr_count), 32'd4);
        chk("wr4_valid", 32'(rd_valid), 32'h1);
        rd_req = 1'b0;
        tick();
        chk("wr4_valid_pulse", 32'(rd_valid), 32'h0);
        chk("wr4_ra_hold", 32'(ra_data), 32'h33);

        // Back-to-back reads give new data every cycle.
        rd_req = 1'b1; ra_addr = 2'd0; rb_addr = 2'd3;
        tick();
        chk("b2b_ra0", 32'(ra_data), 32'h11);
        chk("b2b_rb0", 32'(rb_data), 32'h44);
        ra_addr = 2'd1; rb_addr = 2'd2;
        tick();
        chk("b2b_valid", 32'(rd_valid), 32'h1);
        chk("b2b_ra1", 32'(ra_data), 32'h22);
        chk("b2b_rb1", 32'(rb_data), 32'h33);
        rd_req = 1'b0;
        tick();

        // Write-first bypass on both ports for the same register.
        wsel = 4'b1000; wdata = 8'hA5;
        rd_req = 1'b1; ra_addr = 2'd3; rb_addr = 2'd3;
        tick();
        chk("byp_ra", 32'(ra_data), 32'hA5);
        chk("byp_rb", 32'(rb_data), 32'hA5);
        chk("byp_count", 32'(wr_count), 32'd5);
        wsel = 4'b0000; ra_addr = 2'd3; rb_addr = 2'd0;
        tick();
        chk("byp_later_ra", 32'(ra_data), 32'hA5);
        chk("byp_later_rb", 32'(rb_data), 32'h11);
        rd_req = 1'b0;
        tick();

        // Illegal select with a clear in the same cycle: the set wins.
        wsel = 4'b0110; wdata = 8'hFF; clr_err = 1'b1;
        tick();
        chk("ill_sel_err", 32'(sel_err), 32'h1);
        chk("ill_count", 32'(wr_count), 32'd5);
        wsel = 4'b0000; clr_err = 1'b1;
        tick();
        chk("clr_sel_err", 32'(sel_err), 32'h0);
        clr_err = 1'b0;

        // An illegal select gives no bypass and writes nothing.
        wsel = 4'b0110; wdata = 8'hFF;
        rd_req = 1'b1; ra_addr = 2'd1; rb_addr = 2'd2;
        tick();
        chk("ill_nobyp_ra", 32'(ra_data), 32'h22);
        chk("ill_nobyp_rb", 32'(rb_data), 32'h33);
        chk("ill_sticky", 32'(sel_err), 32'h1);
        wsel = 4'b0000;
        tick();
        chk("ill_keep_ra", 32'(ra_data), 32'h22);
        chk("ill_keep_rb", 32'(rb_data), 32'h33);
        chk("ill_sticky_hold", 32'(sel_err), 32'h1);
        chk("ill_count2", 32'(wr_count), 32'd5);
        rd_req = 1'b0;

        // Saturation: 260 more legal writes to reg0.
        for (int i = 0; i < 260; i++) begin
            wsel  = 4'b0001;
            wdata = 8'(i);
            tick();
            if (i == 249) chk("sat_reach", 32'(wr_count), 32'd255);
        end
        chk("sat_hold", 32'(wr_count), 32'd255);
        wsel = 4'b0000; rd_req = 1'b1; ra_addr = 2'd0; rb_addr = 2'd3;
        tick();
        chk("sat_data", 32'(ra_data), 32'h03);
        chk("sat_count_idle", 32'(wr_count), 32'd255);
        rd_req = 1'b0;

        // Async reset between edges while a write and read are pending.
        wsel = 4'b0001; wdata = 8'h5A; rd_req = 1'b1; ra_addr = 2'd0; rb_addr = 2'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ra", 32'(ra_data), 32'h00);
        chk("arst_rb", 32'(rb_data), 32'h00);
        chk("arst_valid", 32'(rd_valid), 32'h0);
        chk("arst_sel_err", 32'(sel_err), 32'h0);
        chk("arst_count", 32'(wr_count), 32'h0);
        tick();
        chk("arst_held_valid", 32'(rd_valid), 32'h0);
        idle_inputs();
        rst_n = 1'b1;
        tick();
        chk("arst_no_pulse", 32'(rd_valid), 32'h0);
        chk("arst_no_commit", 32'(wr_count), 32'h0);
        rd_req = 1'b1; ra_addr = 2'd0; rb_addr = 2'd3;
        tick();
        chk("arst_reg0", 32'(ra_data), 32'h00);
        chk("arst_reg3", 32'(rb_data), 32'h00);
        chk("arst_read_valid", 32'(rd_valid), 32'h1);
        rd_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
